// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage controller. Consumes the EX/MEM pipeline register, resolves
//   branches, runs loads/stores over a multi-cycle req/ack data-memory
//   handshake, stalls the upstream pipeline while an access is outstanding,
//   and holds the MEM/WB pipeline register.
// Ports
//   clk, reset (synchronous, active-low)
//   EX/MEM inputs : mem_to_reg_in, reg_write_en_in, mem_read_in, mem_write_in,
//                   branch_in, z_flag_in, pc_next_in, alu_out_in, data_in, rd_in
//   Data memory   : dmem_req, dmem_we, dmem_addr, dmem_wdata (out),
//                   dmem_rdata, dmem_ack (in)
//   Control       : stall, pc_src, branch_target, mem_err (sticky timeout flag)
//   MEM/WB        : mem_to_reg_out, reg_write_en_out, read_data_out,
//                   alu_result_out, rd_out
module mem_stage_ctrl #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_en_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            branch_in,
  input  logic            z_flag_in,
  input  logic [XLEN-1:0] pc_next_in,
  input  logic [XLEN-1:0] alu_out_in,
  input  logic [XLEN-1:0] data_in,
  input  logic [4:0]      rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            mem_err,
  output logic            mem_to_reg_out,
  output logic            reg_write_en_out,
  output logic [XLEN-1:0] read_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [4:0]      rd_out
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          access;
  logic          in_idle;
  logic          in_busy;
  logic          timeout_hit;

  assign access      = mem_read_in | mem_write_in;
  assign in_idle     = (state == IDLE);
  assign in_busy     = (state == BUSY);
  // An ack arriving in the last allowed cycle takes priority over the timeout.
  assign timeout_hit = in_busy & ~dmem_ack & (cnt == LAST_CNT);

  // Combinational controls are held low while reset is asserted so the
  // pipeline sees a quiet stage regardless of what EX/MEM presents.
  assign stall         = reset & ((in_idle & access) |
                                  (in_busy & ~dmem_ack & ~timeout_hit));
  assign pc_src        = reset & branch_in & z_flag_in & in_idle;
  assign branch_target = pc_next_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      mem_err          <= 1'b0;
      mem_to_reg_out   <= 1'b0;
      reg_write_en_out <= 1'b0;
      read_data_out    <= '0;
      alu_result_out   <= '0;
      rd_out           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            // Launch the access; store wins if both read and write are set.
            dmem_req         <= 1'b1;
            dmem_we          <= mem_write_in;
            dmem_addr        <= alu_out_in;
            dmem_wdata       <= data_in;
            cnt              <= '0;
            state            <= BUSY;
            reg_write_en_out <= 1'b0;
          end else begin
            mem_to_reg_out   <= mem_to_reg_in;
            reg_write_en_out <= reg_write_en_in;
            alu_result_out   <= alu_out_in;
            rd_out           <= rd_in;
          end
        end
        BUSY: begin
          if (dmem_ack || timeout_hit) begin
            // EX/MEM was frozen during BUSY, so its fields still describe
            // the instruction that owns this access.
            mem_to_reg_out   <= mem_to_reg_in;
            alu_result_out   <= alu_out_in;
            rd_out           <= rd_in;
            reg_write_en_out <= dmem_ack ? reg_write_en_in : 1'b0;
            if (!dmem_we) begin
              read_data_out <= dmem_ack ? dmem_rdata : '0;
            end
            if (!dmem_ack) begin
              mem_err <= 1'b1;
            end
            dmem_req <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt              <= cnt + 1'b1;
            reg_write_en_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_reg_in, reg_write_en_in, mem_read_in, mem_write_in;
  logic        branch_in, z_flag_in;
  logic [63:0] pc_next_in, alu_out_in, data_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src, mem_err;
  logic [63:0] branch_target;
  logic        mem_to_reg_out, reg_write_en_out;
  logic [63:0] read_data_out, alu_result_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_en_in(reg_write_en_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .branch_in(branch_in), .z_flag_in(z_flag_in),
    .pc_next_in(pc_next_in), .alu_out_in(alu_out_in), .data_in(data_in),
    .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .mem_err(mem_err),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_en_out(reg_write_en_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .rd_out(rd_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_to_reg_in = 0; reg_write_en_in = 0; mem_read_in = 0; mem_write_in = 0;
    branch_in = 0; z_flag_in = 0; pc_next_in = '0; alu_out_in = '0;
    data_in = '0; rd_in = '0; dmem_rdata = '0; dmem_ack = 0;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    // Reset held for two edges with every input toggling
    #1;
    mem_to_reg_in = 1; reg_write_en_in = 1; mem_read_in = 1; mem_write_in = 1;
    branch_in = 1; z_flag_in = 1; pc_next_in = '1; alu_out_in = '1;
    data_in = '1; rd_in = '1; dmem_rdata = '1; dmem_ack = 1;
    #1;
    chk("rst_stall_a", stall, 0);
    chk("rst_pcsrc_a", pc_src, 0);
    tick();
    clear_inputs();
    tick();
    mem_read_in = 1; dmem_ack = 1; rd_in = 5'h1F;
    #1;
    chk("rst_stall_b", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_memerr", mem_err, 0);
    chk("rst_rwe", reg_write_en_out, 0);
    chk("rst_m2r", mem_to_reg_out, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_alu", alu_result_out, 0);
    chk("rst_rd", rd_out, 0);
    clear_inputs();
    reset = 1;
    tick();

    // ALU op
    rd_in = 5; alu_out_in = 64'h2A; reg_write_en_in = 1;
    #1;
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_rd", rd_out, 5);
    chk("alu_res", alu_result_out, 64'h2A);
    chk("alu_rwe", reg_write_en_out, 1);
    chk("alu_stall2", stall, 0);
    clear_inputs();
    tick();
    chk("alu_rwe_nop", reg_write_en_out, 0);

    // Load at 0x100 acked after 3 BUSY cycles
    mem_read_in = 1; alu_out_in = 64'h100; rd_in = 7; reg_write_en_in = 1; mem_to_reg_in = 1;
    #1;
    chk("ld_stall_idle", stall, 1);
    tick();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 64'h100);
    chk("ld_bubble", reg_write_en_out, 0);
    chk("ld_stall_b1", stall, 1);
    tick();
    chk("ld_stall_b2", stall, 1);
    tick();
    chk("ld_stall_b3", stall, 1);
    tick();
    dmem_ack = 1; dmem_rdata = 64'hDEAD;
    #1;
    chk("ld_stall_ack", stall, 0);
    tick();
    clear_inputs();
    chk("ld_rdata", read_data_out, 64'hDEAD);
    chk("ld_rwe", reg_write_en_out, 1);
    chk("ld_rd", rd_out, 7);
    chk("ld_m2r", mem_to_reg_out, 1);
    chk("ld_req_drop", dmem_req, 0);
    tick();
    chk("ld_single_wb", reg_write_en_out, 0);

    // Store acked in first BUSY cycle
    mem_write_in = 1; alu_out_in = 64'h200; data_in = 64'h1234;
    #1;
    chk("st_stall_idle", stall, 1);
    tick();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 64'h1234);
    chk("st_addr", dmem_addr, 64'h200);
    dmem_ack = 1;
    #1;
    chk("st_stall_ack", stall, 0);
    tick();
    clear_inputs();
    chk("st_req_drop", dmem_req, 0);
    chk("st_rwe", reg_write_en_out, 0);
    chk("st_rdata_held", read_data_out, 64'hDEAD);

    // Load that never gets an ack -> timeout after 16 BUSY cycles
    mem_read_in = 1; alu_out_in = 64'h300; rd_in = 9; reg_write_en_in = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_req_%0d", i), dmem_req, 1);
      chk($sformatf("to_stall_%0d", i), stall, 1);
      tick();
    end
    chk("to_req_last", dmem_req, 1);
    chk("to_stall_last", stall, 0);
    chk("to_err_pre", mem_err, 0);
    tick();
    clear_inputs();
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_rwe", reg_write_en_out, 0);
    chk("to_rdata", read_data_out, 0);
    tick();
    chk("to_err_sticky", mem_err, 1);

    // Branch resolution
    branch_in = 1; z_flag_in = 1; pc_next_in = 64'h400;
    #1;
    chk("br_pcsrc", pc_src, 1);
    chk("br_target", branch_target, 64'h400);
    chk("br_stall", stall, 0);
    z_flag_in = 0;
    #1;
    chk("br_notaken", pc_src, 0);
    tick();
    clear_inputs();

    // Reset during the 2nd BUSY cycle; a late ack must be ignored
    mem_read_in = 1; alu_out_in = 64'h500; rd_in = 3; reg_write_en_in = 1;
    tick();
    tick();
    chk("rb_req_b2", dmem_req, 1);
    reset = 0;
    clear_inputs();
    tick();
    chk("rb_req", dmem_req, 0);
    chk("rb_err_clr", mem_err, 0);
    chk("rb_rwe", reg_write_en_out, 0);
    reset = 1;
    dmem_ack = 1; dmem_rdata = 64'hBEEF;
    #1;
    chk("rb_stall", stall, 0);
    tick();
    clear_inputs();
    chk("rb_rdata", read_data_out, 0);
    chk("rb_rwe2", reg_write_en_out, 0);
    chk("rb_req2", dmem_req, 0);

    // Ack arriving in the timeout cycle wins
    mem_read_in = 1; alu_out_in = 64'h600; rd_in = 4; reg_write_en_in = 1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    dmem_ack = 1; dmem_rdata = 64'h77;
    #1;
    chk("tw_stall", stall, 0);
    tick();
    clear_inputs();
    chk("tw_err", mem_err, 0);
    chk("tw_rwe", reg_write_en_out, 1);
    chk("tw_rdata", read_data_out, 64'h77);
    chk("tw_req", dmem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
